// File: rtl/glitcbus_pkg.sv
// Shared encodings for the GLITCBUS slave: FSM states (one per bus phase), direction and width constants.
package glitcbus_pkg;

  localparam int   BYTES    = 4;
  localparam logic GB_WRITE = 1'b1;

  // States track the bus phases as seen through the input flops
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_AHI,
    ST_ALO,
    ST_WAIT1,
    ST_WAIT2,
    ST_B3,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_WCOMMIT,
    ST_DESEL
  } state_t;

endpackage

// File: rtl/glitcbus_slave_iob.sv
// Pin-level flops for the GLITCBUS: registered select/direction/GAD inputs, GAD output and OE flops,
// and the GAD tristate driver. OE clears asynchronously on reset so the slave releases the bus at once.
module glitcbus_slave_iob
  import glitcbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_pin,
  input  logic       rdwr_pin,
  inout  wire  [7:0] gad_pin,
  input  logic [7:0] out_d,
  input  logic       oe_d,
  output logic       sel,
  output logic       rdwr,
  output logic [7:0] gad
);

  (* IOB = "TRUE" *) logic       sel_q;
  (* IOB = "TRUE" *) logic       rdwr_q;
  (* IOB = "TRUE" *) logic [7:0] gad_q;
  (* IOB = "TRUE" *) logic [7:0] out_q;
  (* IOB = "TRUE" *) logic       oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 1'b0;
      rdwr_q <= 1'b0;
      gad_q  <= 8'h00;
      out_q  <= 8'h00;
      oe_q   <= 1'b0;
    end else begin
      sel_q  <= sel_pin;
      rdwr_q <= rdwr_pin;
      gad_q  <= gad_pin;
      out_q  <= out_d;
      oe_q   <= oe_d;
    end
  end

  assign sel     = sel_q;
  assign rdwr    = rdwr_q;
  assign gad     = gad_q;
  assign gad_pin = oe_q ? out_q : 8'hzz;

endmodule

// File: rtl/glitcbus_slave.sv
// GLITC-side GLITCBUS responder: decodes select/address/wait/data phases and issues one 32-bit
// register read or write per transaction; read data is shifted back onto GAD MSB-first.
module glitcbus_slave
  import glitcbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  GSEL_B,
  input  logic                  GRDWR_B,
  inout  wire  [7:0]            GAD,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  wr_o,
  output logic                  rd_o,
  input  logic [DATA_WIDTH-1:0] dat_i
);

  if (ADDR_WIDTH != 16) begin : g_bad_addr_width
    $error("glitcbus_slave: ADDR_WIDTH must be 16 (two address bytes on the bus)");
  end
  if (DATA_WIDTH != BYTES * 8) begin : g_bad_data_width
    $error("glitcbus_slave: DATA_WIDTH must be 32 (four data bytes on the bus)");
  end

  logic                  sel_q;
  logic                  rdwr_q;
  logic [7:0]            gad_q;
  logic [7:0]            out_d;
  logic                  oe_d;

  state_t                state_q, state_d;
  logic                  sel_prev_q;
  logic [7:0]            adr_hi_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic                  dir_q;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  adr_ld;
  logic                  in_txn;
  logic                  abort;
  logic                  is_rd;

  glitcbus_slave_iob u_iob (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .sel_pin  (GSEL_B),
    .rdwr_pin (GRDWR_B),
    .gad_pin  (GAD),
    .out_d    (out_d),
    .oe_d     (oe_d),
    .sel      (sel_q),
    .rdwr     (rdwr_q),
    .gad      (gad_q)
  );

  assign in_txn = (state_q inside {ST_AHI, ST_ALO, ST_WAIT1, ST_WAIT2, ST_B3, ST_B2, ST_B1, ST_B0});
  assign abort  = in_txn && sel_q;
  assign is_rd  = (dir_q != GB_WRITE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      sel_prev_q <= 1'b0;
      adr_hi_q   <= 8'h00;
      adr_q      <= '0;
      dir_q      <= 1'b0;
      sh_q       <= '0;
    end else begin
      state_q    <= state_d;
      sel_prev_q <= sel_q;
      sh_q       <= sh_d;
      if (state_q == ST_AHI) adr_hi_q <= gad_q;
      if (adr_ld) begin
        adr_q <= {adr_hi_q, gad_q};
        dir_q <= rdwr_q;
      end
    end
  end

  // The GAD output flop runs one phase ahead of the state: the byte loaded
  // in state S is on the pins while the input flops sample the next phase.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    out_d   = 8'h00;
    oe_d    = 1'b0;
    adr_ld  = 1'b0;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_prev_q && !sel_q) state_d = ST_AHI;
      end
      ST_AHI: state_d = ST_ALO;
      ST_ALO: begin
        adr_ld  = 1'b1;
        rd_o    = (rdwr_q != GB_WRITE);
        state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (is_rd) begin
          sh_d  = dat_i;
          out_d = dat_i[DATA_WIDTH-1 -: 8];
          oe_d  = 1'b1;
        end
        state_d = ST_WAIT2;
      end
      ST_WAIT2, ST_B3, ST_B2: begin
        if (is_rd) begin
          out_d = sh_q[DATA_WIDTH-9 -: 8];
          oe_d  = 1'b1;
          sh_d  = sh_q << 8;
        end else if (state_q != ST_WAIT2) begin
          sh_d = {sh_q[DATA_WIDTH-9:0], gad_q};
        end
        state_d = (state_q == ST_WAIT2) ? ST_B3 :
                  (state_q == ST_B3)    ? ST_B2 : ST_B1;
      end
      ST_B1: begin
        if (!is_rd) sh_d = {sh_q[DATA_WIDTH-9:0], gad_q};
        state_d = ST_B0;
      end
      ST_B0: begin
        if (!is_rd) begin
          sh_d    = {sh_q[DATA_WIDTH-9:0], gad_q};
          state_d = ST_WCOMMIT;
        end else begin
          state_d = ST_DESEL;
        end
      end
      ST_WCOMMIT: begin
        wr_o    = 1'b1;
        state_d = ST_DESEL;
      end
      ST_DESEL: begin
        if (sel_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      sh_d    = sh_q;
      out_d   = 8'h00;
      oe_d    = 1'b0;
      adr_ld  = 1'b0;
      rd_o    = 1'b0;
    end
  end

  assign adr_o = adr_ld ? {adr_hi_q, gad_q} : adr_q;
  assign dat_o = sh_q;

endmodule

// File: tb/tb_glitcbus_slave.sv
// Scoreboard bench for glitcbus_slave: a bus-master task pushes expected strobes and GAD bytes
// (with their cycle numbers); a negedge monitor pops and compares them as the slave produces them.
module tb_glitcbus_slave;

  logic        clk_i   = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        GSEL_B  = 1'b1;
  logic        GRDWR_B = 1'b0;
  logic        m_oe    = 1'b0;
  logic [7:0]  m_dat   = 8'h00;
  wire  [7:0]  GAD;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic        wr_o;
  logic        rd_o;
  logic [31:0] dat_i   = 32'h0;

  assign GAD = m_oe ? m_dat : 8'hzz;

  glitcbus_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .GSEL_B  (GSEL_B),
    .GRDWR_B (GRDWR_B),
    .GAD     (GAD),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .wr_o    (wr_o),
    .rd_o    (rd_o),
    .dat_i   (dat_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] adr;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t byte_q[$];
  exp_t mon_e;

  wire slave_oe = dut.u_iob.oe_q;

  // Register-port responder: read data present only in the cycle after rd_o
  logic [31:0] rsp_word = 32'h0;
  logic        rd_seen  = 1'b0;
  always @(negedge clk_i) rd_seen = rd_o;
  always @(posedge clk_i) begin
    #1;
    dat_i = rd_seen ? rsp_word : 32'h0;
  end

  always @(negedge clk_i) begin
    if (rd_o) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected cyc=%0d got rd_o=1 required rd_o=0", cyc);
      end else begin
        mon_e = rd_q.pop_front();
        if (cyc != mon_e.cyc || adr_o !== mon_e.adr) begin
          errors++;
          $display("FAIL rd_strobe got cyc=%0d adr=%h required cyc=%0d adr=%h", cyc, adr_o, mon_e.cyc, mon_e.adr);
        end
      end
    end
    if (wr_o) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected cyc=%0d got wr_o=1 required wr_o=0", cyc);
      end else begin
        mon_e = wr_q.pop_front();
        if (cyc != mon_e.cyc || adr_o !== mon_e.adr || dat_o !== mon_e.val) begin
          errors++;
          $display("FAIL wr_strobe got cyc=%0d adr=%h dat=%h required cyc=%0d adr=%h dat=%h",
                   cyc, adr_o, dat_o, mon_e.cyc, mon_e.adr, mon_e.val);
        end
      end
    end
    if (slave_oe) begin
      checks++;
      if (byte_q.size() == 0) begin
        errors++;
        $display("FAIL gad_unexpected_drive cyc=%0d got oe=1 gad=%h required oe=0", cyc, GAD);
      end else begin
        mon_e = byte_q.pop_front();
        if (cyc != mon_e.cyc || GAD !== mon_e.val[7:0] || m_oe !== 1'b0) begin
          errors++;
          $display("FAIL gad_byte got cyc=%0d gad=%h master_oe=%b required cyc=%0d gad=%h master_oe=0",
                   cyc, GAD, m_oe, mon_e.cyc, mon_e.val[7:0]);
        end
      end
    end
  end

  // Drives phases P0..min(stop,9)-1 starting at the next cycle. Full transactions end with
  // one select-high cycle; shortened ones return at the start of pin phase 'stop'.
  task automatic bus_txn(input logic wr, input logic [15:0] adr, input logic [31:0] dat,
                         input int stop, input bit flip);
    int         c;
    logic [7:0] b [9];
    exp_t       e;
    b[0] = 8'h5A;        b[1] = adr[15:8];    b[2] = adr[7:0];
    b[3] = 8'h00;        b[4] = 8'h00;
    b[5] = dat[31:24];   b[6] = dat[23:16];   b[7] = dat[15:8];   b[8] = dat[7:0];
    @(posedge clk_i); #1;
    c = cyc;
    if (!wr) rsp_word = dat;
    if (!wr && stop > 3) begin
      e.cyc = c + 3; e.adr = adr; e.val = 32'h0; rd_q.push_back(e);
    end
    if (wr && stop >= 9) begin
      e.cyc = c + 10; e.adr = adr; e.val = dat; wr_q.push_back(e);
    end
    if (!wr) begin
      for (int k = 5; k < 9; k++) begin
        if (k < stop) begin
          e.cyc = c + k; e.adr = adr; e.val = {24'h0, b[k]}; byte_q.push_back(e);
        end
      end
    end
    for (int p = 0; p < 9 && p < stop; p++) begin
      if (p > 0) begin @(posedge clk_i); #1; end
      GSEL_B  = 1'b0;
      GRDWR_B = (flip && p > 2) ? ~wr : wr;
      m_oe    = wr || (p < 3);
      m_dat   = b[p];
    end
    @(posedge clk_i); #1;
    if (stop >= 9) begin
      GSEL_B = 1'b1;
      m_oe   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      GSEL_B = 1'b1;
      m_oe   = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2 rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({rd_o, wr_o, slave_oe} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes_oe got %b required 000", {rd_o, wr_o, slave_oe});
    end
    checks++;
    if (adr_o !== 16'h0 || dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_data got adr=%h dat=%h required 0000 00000000", adr_o, dat_o);
    end
    @(posedge clk_i); #1 rst_n_i = 1'b1;
    idle(3);
    @(negedge clk_i);
    checks++;
    if ({rd_o, wr_o, slave_oe} !== 3'b000 || adr_o !== 16'h0 || dat_o !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_idle got rd=%b wr=%b oe=%b adr=%h dat=%h required all 0",
               rd_o, wr_o, slave_oe, adr_o, dat_o);
    end
  endtask

  task automatic test_write;
    bus_txn(1'b1, 16'h1234, 32'hDEADBEEF, 9, 1'b0);
    idle(4);
    @(negedge clk_i);
    checks++;
    if (wr_q.size() != 0 || byte_q.size() != 0) begin
      errors++; $display("FAIL write_missing got pending wr=%0d bytes=%0d required 0 0", wr_q.size(), byte_q.size());
    end
    checks++;
    if (adr_o !== 16'h1234) begin
      errors++; $display("FAIL write_adr_hold got %h required 1234", adr_o);
    end
  endtask

  task automatic test_read;
    bus_txn(1'b0, 16'h00A5, 32'hCAFEF00D, 9, 1'b0);
    idle(3);
    @(negedge clk_i);
    checks++;
    if (rd_q.size() != 0 || byte_q.size() != 0) begin
      errors++; $display("FAIL read_missing got pending rd=%0d bytes=%0d required 0 0", rd_q.size(), byte_q.size());
    end
    checks++;
    if (adr_o !== 16'h00A5) begin
      errors++; $display("FAIL read_adr_hold got %h required 00a5", adr_o);
    end
  endtask

  task automatic test_abort;
    bus_txn(1'b1, 16'h4321, 32'h12345678, 6, 1'b0);
    GSEL_B = 1'b1;
    m_oe   = 1'b0;
    idle(4);
    bus_txn(1'b1, 16'h0001, 32'h00000001, 9, 1'b1);
    idle(4);
    @(negedge clk_i);
    checks++;
    if (wr_q.size() != 0 || byte_q.size() != 0) begin
      errors++; $display("FAIL abort_then_write got pending wr=%0d bytes=%0d required 0 0", wr_q.size(), byte_q.size());
    end
    checks++;
    if (dat_o !== 32'h00000001 || adr_o !== 16'h0001) begin
      errors++; $display("FAIL abort_then_write_regs got adr=%h dat=%h required 0001 00000001", adr_o, dat_o);
    end
  endtask

  task automatic test_back_to_back;
    bus_txn(1'b0, 16'h0010, 32'h89ABCDEF, 9, 1'b0);
    bus_txn(1'b0, 16'h0011, 32'h01234567, 9, 1'b1);
    idle(3);
    @(negedge clk_i);
    checks++;
    if (rd_q.size() != 0 || byte_q.size() != 0) begin
      errors++; $display("FAIL b2b_missing got pending rd=%0d bytes=%0d required 0 0", rd_q.size(), byte_q.size());
    end
  endtask

  task automatic test_reset_mid_read;
    bus_txn(1'b0, 16'h0BAD, 32'hCAFEF00D, 6, 1'b0);
    m_oe    = 1'b0;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (slave_oe !== 1'b0) begin
      errors++; $display("FAIL rst_mid_read_oe got %b required 0", slave_oe);
    end
    checks++;
    if ({rd_o, wr_o} !== 2'b00 || adr_o !== 16'h0 || dat_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_read_outputs got rd=%b wr=%b adr=%h dat=%h required all 0", rd_o, wr_o, adr_o, dat_o);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (12) begin
      @(posedge clk_i); #1;
      GSEL_B  = 1'b0;
      GRDWR_B = 1'b0;
      m_oe    = 1'b1;
      m_dat   = 8'($urandom);
    end
    idle(2);
    checks++;
    if (rd_q.size() != 0 || byte_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_read_pending got rd=%0d bytes=%0d required 0 0", rd_q.size(), byte_q.size());
    end
    bus_txn(1'b0, 16'h0BAD, 32'h600DF00D, 9, 1'b0);
    idle(3);
    @(negedge clk_i);
    checks++;
    if (rd_q.size() != 0 || byte_q.size() != 0) begin
      errors++; $display("FAIL rst_recover_read got pending rd=%0d bytes=%0d required 0 0", rd_q.size(), byte_q.size());
    end
  endtask

  task automatic test_sel_low_at_reset;
    logic seen;
    seen = 1'b0;
    @(posedge clk_i); #1;
    GSEL_B  = 1'b0;
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (15) begin
      @(negedge clk_i);
      seen = seen | rd_o | wr_o | slave_oe;
      @(posedge clk_i); #1;
      GRDWR_B = 1'b0;
      m_oe    = 1'b1;
      m_dat   = 8'($urandom);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL sel_low_reset_activity got %b required 0", seen);
    end
    idle(1);
    bus_txn(1'b1, 16'hBEE5, 32'hA5A55A5A, 9, 1'b0);
    idle(4);
    @(negedge clk_i);
    checks++;
    if (wr_q.size() != 0 || dat_o !== 32'hA5A55A5A) begin
      errors++; $display("FAIL sel_low_then_write got pending=%0d dat=%h required 0 a5a55a5a", wr_q.size(), dat_o);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_abort;
    test_back_to_back;
    test_reset_mid_read;
    test_sel_low_at_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
